qam_symbol_scheduler: RTL

// Symbol-rate controller that feeds the 16QAM/QPSK constellation mapper. Accepts a

---
 rtl/qam_symbol_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/qam_symbol_scheduler.sv
// Packs a serial bit stream into 2-bit (QPSK) or 4-bit (16QAM) symbol words and
// releases one word per symbol period to the constellation mapper.
module qam_symbol_scheduler #(
    parameter int SYM_DIV = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mod_type,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [3:0]       parallel_out,
    output logic             sym_valid,
    output logic             underflow,
    output logic [CNT_W-1:0] sym_count
);

    localparam int DIV_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       word_q, word_d;
    logic [3:0]       out_q, out_d;
    logic             mode_q, mode_d;
    logic             sym_valid_q, sym_valid_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       tick;
    logic       accept;
    logic       mode_eff;
    logic [2:0] need;

    assign tick      = enable && (div_cnt_q == DIV_W'(SYM_DIV - 1));
    assign bit_ready = enable && (state_q == COLLECT);
    assign accept    = bit_valid && bit_ready;
    // The first bit of a symbol uses the live mod_type; later bits use the latched one.
    assign mode_eff  = (bit_cnt_q == 3'd0) ? mod_type : mode_q;
    assign need      = mode_eff ? 3'd4 : 3'd2;

    assign parallel_out = out_q;
    assign sym_valid    = sym_valid_q;
    assign underflow    = underflow_q;
    assign sym_count    = cnt_q;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        word_d      = word_q;
        out_d       = out_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        sym_valid_d = 1'b0;
        underflow_d = 1'b0;

        if (!enable) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (!enable) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            word_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: state_d = COLLECT;
                COLLECT: begin
                    if (accept) begin
                        if (bit_cnt_q == 3'd0) begin
                            mode_d = mod_type;
                            word_d = {bit_in, 3'b000};
                        end else begin
                            word_d[2'(3 - bit_cnt_q)] = bit_in;
                        end
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q + 3'd1 == need) state_d = FULL;
                    end
                    // A word completing on the tick cycle still counts as late.
                    if (tick) underflow_d = 1'b1;
                end
                FULL: begin
                    if (tick) begin
                        out_d       = word_q;
                        sym_valid_d = 1'b1;
                        cnt_d       = cnt_q + CNT_W'(1);
                        state_d     = COLLECT;
                        bit_cnt_d   = 3'd0;
                        word_d      = 4'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= 3'd0;
            word_q      <= 4'd0;
            out_q       <= 4'd0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            sym_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            out_q       <= out_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            sym_valid_q <= sym_valid_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
